// File: rtl/mmu_l2tlb_refill_ctrl.sv
// L2 TLB lookup/refill controller: 4-way set compare, page-table-walk on miss,
// victim selection (free way first, else PLRU suggestion) and refill write-back.
module mmu_l2tlb_refill_ctrl #(
    parameter int VPN_W = 27,
    parameter int SET_W = 6,
    parameter int PPN_W = 44
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_flush,
    input  logic                   i_req_valid,
    output logic                   o_req_ready,
    input  logic [VPN_W-1:0]       i_req_vpn,
    output logic                   o_rd_en,
    output logic [SET_W-1:0]       o_rd_set,
    input  logic [3:0]             i_rd_valid_4,
    input  logic [4*(VPN_W-SET_W)-1:0] i_rd_tag_4,
    input  logic [4*PPN_W-1:0]     i_rd_ppn_4,
    output logic                   o_resp_valid,
    output logic                   o_resp_hit,
    output logic                   o_resp_fault,
    output logic [PPN_W-1:0]       o_resp_ppn,
    output logic                   o_ptw_req_valid,
    input  logic                   i_ptw_req_ready,
    output logic [VPN_W-1:0]       o_ptw_req_vpn,
    input  logic                   i_ptw_resp_valid,
    input  logic [PPN_W-1:0]       i_ptw_resp_ppn,
    input  logic                   i_ptw_resp_fault,
    output logic                   o_wr_en,
    output logic [SET_W-1:0]       o_wr_set,
    output logic [3:0]             o_wr_way_4,
    output logic [VPN_W-SET_W-1:0] o_wr_tag,
    output logic [PPN_W-1:0]       o_wr_ppn,
    input  logic [3:0]             i_replace_way_4,
    output logic [3:0]             o_update_way_4
);
    localparam int TAG_W = VPN_W - SET_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_PTW_REQ,
        S_PTW_WAIT,
        S_REFILL
    } state_e;

    state_e           state_q, state_d;
    logic             drop_pending_q, drop_pending_d;
    logic [VPN_W-1:0] vpn_q, vpn_d;
    logic [3:0]       valid_q, valid_d;
    logic [PPN_W-1:0] ppn_q, ppn_d;

    logic [TAG_W-1:0] cap_tag;
    logic [3:0]       hit_vec;
    logic [3:0]       hit_way;
    logic [PPN_W-1:0] hit_ppn;
    logic [3:0]       victim_way;

    // Isolates the lowest set bit; returns zero for an all-zero vector.
    function automatic logic [3:0] lowest_one(input logic [3:0] v);
        lowest_one = v & (~v + 4'd1);
    endfunction

    assign cap_tag = vpn_q[VPN_W-1:SET_W];

    always_comb begin
        hit_vec = '0;
        for (int k = 0; k < 4; k++) begin
            hit_vec[k] = i_rd_valid_4[k] && (i_rd_tag_4[k*TAG_W +: TAG_W] == cap_tag);
        end
    end

    assign hit_way = lowest_one(hit_vec);

    always_comb begin
        hit_ppn = '0;
        for (int k = 0; k < 4; k++) begin
            if (hit_way[k]) begin
                hit_ppn = i_rd_ppn_4[k*PPN_W +: PPN_W];
            end
        end
    end

    // A free way is always preferred so the PLRU only arbitrates a full set.
    assign victim_way = (&valid_q) ? i_replace_way_4 : lowest_one(~valid_q);

    always_comb begin
        state_d         = state_q;
        drop_pending_d  = drop_pending_q;
        vpn_d           = vpn_q;
        valid_d         = valid_q;
        ppn_d           = ppn_q;
        o_req_ready     = 1'b0;
        o_rd_en         = 1'b0;
        o_rd_set        = '0;
        o_resp_valid    = 1'b0;
        o_resp_hit      = 1'b0;
        o_resp_fault    = 1'b0;
        o_resp_ppn      = '0;
        o_ptw_req_valid = 1'b0;
        o_ptw_req_vpn   = '0;
        o_wr_en         = 1'b0;
        o_wr_set        = '0;
        o_wr_way_4      = '0;
        o_wr_tag        = '0;
        o_wr_ppn        = '0;
        o_update_way_4  = '0;

        if (drop_pending_q && i_ptw_resp_valid) begin
            drop_pending_d = 1'b0;
        end

        unique case (state_q)
            S_IDLE: begin
                o_req_ready = ~i_flush & ~rst;
                if (i_req_valid && o_req_ready) begin
                    o_rd_en  = 1'b1;
                    o_rd_set = i_req_vpn[SET_W-1:0];
                    vpn_d    = i_req_vpn;
                    state_d  = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                valid_d = i_rd_valid_4;
                if (i_flush) begin
                    state_d = S_IDLE;
                end else if (|hit_vec) begin
                    o_resp_valid   = 1'b1;
                    o_resp_hit     = 1'b1;
                    o_resp_ppn     = hit_ppn;
                    o_update_way_4 = hit_way;
                    state_d        = S_IDLE;
                end else begin
                    state_d = S_PTW_REQ;
                end
            end
            S_PTW_REQ: begin
                o_ptw_req_valid = ~drop_pending_q;
                o_ptw_req_vpn   = vpn_q;
                if (o_ptw_req_valid && i_ptw_req_ready) begin
                    // A walk launched in the flush cycle still returns later.
                    if (i_flush) begin
                        drop_pending_d = 1'b1;
                        state_d        = S_IDLE;
                    end else begin
                        state_d = S_PTW_WAIT;
                    end
                end else if (i_flush) begin
                    state_d = S_IDLE;
                end
            end
            S_PTW_WAIT: begin
                if (i_flush) begin
                    if (!i_ptw_resp_valid) begin
                        drop_pending_d = 1'b1;
                    end
                    state_d = S_IDLE;
                end else if (i_ptw_resp_valid) begin
                    if (i_ptw_resp_fault) begin
                        o_resp_valid = 1'b1;
                        o_resp_fault = 1'b1;
                        state_d      = S_IDLE;
                    end else begin
                        ppn_d   = i_ptw_resp_ppn;
                        state_d = S_REFILL;
                    end
                end
            end
            S_REFILL: begin
                if (!i_flush) begin
                    o_wr_en        = 1'b1;
                    o_wr_set       = vpn_q[SET_W-1:0];
                    o_wr_tag       = cap_tag;
                    o_wr_ppn       = ppn_q;
                    o_wr_way_4     = victim_way;
                    o_update_way_4 = victim_way;
                    o_resp_valid   = 1'b1;
                    o_resp_ppn     = ppn_q;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            drop_pending_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            drop_pending_q <= drop_pending_d;
        end
    end

    always_ff @(posedge clk) begin
        vpn_q   <= vpn_d;
        valid_q <= valid_d;
        ppn_q   <= ppn_d;
    end

endmodule

// File: tb/tb_mmu_l2tlb_refill_ctrl.sv
// Bench for mmu_l2tlb_refill_ctrl: tag/data array model, scoreboard of expected
// responses from a set-level TLB reference model, directed and random traffic.
module tb_mmu_l2tlb_refill_ctrl;
    localparam int VPN_W = 27;
    localparam int SET_W = 6;
    localparam int PPN_W = 44;
    localparam int TAG_W = VPN_W - SET_W;
    localparam int NS    = 64;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 i_flush = 1'b0;
    logic                 i_req_valid = 1'b0;
    logic                 o_req_ready;
    logic [VPN_W-1:0]     i_req_vpn = '0;
    logic                 o_rd_en;
    logic [SET_W-1:0]     o_rd_set;
    logic [3:0]           i_rd_valid_4 = '0;
    logic [4*TAG_W-1:0]   i_rd_tag_4 = '0;
    logic [4*PPN_W-1:0]   i_rd_ppn_4 = '0;
    logic                 o_resp_valid, o_resp_hit, o_resp_fault;
    logic [PPN_W-1:0]     o_resp_ppn;
    logic                 o_ptw_req_valid;
    logic                 i_ptw_req_ready = 1'b0;
    logic [VPN_W-1:0]     o_ptw_req_vpn;
    logic                 i_ptw_resp_valid = 1'b0;
    logic [PPN_W-1:0]     i_ptw_resp_ppn = '0;
    logic                 i_ptw_resp_fault = 1'b0;
    logic                 o_wr_en;
    logic [SET_W-1:0]     o_wr_set;
    logic [3:0]           o_wr_way_4;
    logic [TAG_W-1:0]     o_wr_tag;
    logic [PPN_W-1:0]     o_wr_ppn;
    logic [3:0]           i_replace_way_4 = 4'b0001;
    logic [3:0]           o_update_way_4;

    always #5 clk = ~clk;

    mmu_l2tlb_refill_ctrl #(.VPN_W(VPN_W), .SET_W(SET_W), .PPN_W(PPN_W)) dut (
        .clk(clk), .rst(rst), .i_flush(i_flush),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_vpn(i_req_vpn),
        .o_rd_en(o_rd_en), .o_rd_set(o_rd_set),
        .i_rd_valid_4(i_rd_valid_4), .i_rd_tag_4(i_rd_tag_4), .i_rd_ppn_4(i_rd_ppn_4),
        .o_resp_valid(o_resp_valid), .o_resp_hit(o_resp_hit), .o_resp_fault(o_resp_fault),
        .o_resp_ppn(o_resp_ppn),
        .o_ptw_req_valid(o_ptw_req_valid), .i_ptw_req_ready(i_ptw_req_ready),
        .o_ptw_req_vpn(o_ptw_req_vpn),
        .i_ptw_resp_valid(i_ptw_resp_valid), .i_ptw_resp_ppn(i_ptw_resp_ppn),
        .i_ptw_resp_fault(i_ptw_resp_fault),
        .o_wr_en(o_wr_en), .o_wr_set(o_wr_set), .o_wr_way_4(o_wr_way_4),
        .o_wr_tag(o_wr_tag), .o_wr_ppn(o_wr_ppn),
        .i_replace_way_4(i_replace_way_4), .o_update_way_4(o_update_way_4)
    );

    // Physical array contents (written by the DUT) and the reference TLB model.
    logic             mem_v [NS][4];
    logic [TAG_W-1:0] mem_t [NS][4];
    logic [PPN_W-1:0] mem_p [NS][4];
    logic             ref_v [NS][4];
    logic [TAG_W-1:0] ref_t [NS][4];
    logic [PPN_W-1:0] ref_p [NS][4];

    typedef struct {
        logic             hit;
        logic             fault;
        logic [PPN_W-1:0] ppn;
        logic             wr;
        logic [3:0]       way;
        logic [VPN_W-1:0] vpn;
    } exp_t;

    exp_t expq[$];
    int   tq[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (o_rd_en) begin
            for (int k = 0; k < 4; k++) begin
                i_rd_valid_4[k]               <= mem_v[int'(o_rd_set)][k];
                i_rd_tag_4[k*TAG_W +: TAG_W] <= mem_t[int'(o_rd_set)][k];
                i_rd_ppn_4[k*PPN_W +: PPN_W] <= mem_p[int'(o_rd_set)][k];
            end
        end
        if (o_wr_en) begin
            for (int k = 0; k < 4; k++) begin
                if (o_wr_way_4[k]) begin
                    mem_v[int'(o_wr_set)][k] = 1'b1;
                    mem_t[int'(o_wr_set)][k] = o_wr_tag;
                    mem_p[int'(o_wr_set)][k] = o_wr_ppn;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model: what the TLB must answer for this lookup and what it becomes.
    function automatic bit predict(input logic [VPN_W-1:0] vpn, input logic [3:0] repl,
                                   input bit fault, input logic [PPN_W-1:0] ppn);
        int s = int'(vpn[SET_W-1:0]);
        logic [TAG_W-1:0] tag = vpn[VPN_W-1:SET_W];
        int hw = -1;
        int fw = -1;
        exp_t e;
        for (int k = 0; k < 4; k++)
            if (hw < 0 && ref_v[s][k] && ref_t[s][k] == tag) hw = k;
        e.vpn = vpn;
        if (hw >= 0) begin
            e.hit = 1; e.fault = 0; e.ppn = ref_p[s][hw]; e.wr = 0; e.way = 4'(1 << hw);
        end else if (fault) begin
            e.hit = 0; e.fault = 1; e.ppn = '0; e.wr = 0; e.way = '0;
        end else begin
            for (int k = 0; k < 4; k++)
                if (fw < 0 && !ref_v[s][k]) fw = k;
            e.way = (fw >= 0) ? 4'(1 << fw) : repl;
            e.hit = 0; e.fault = 0; e.ppn = ppn; e.wr = 1;
            for (int k = 0; k < 4; k++) begin
                if (e.way[k]) begin
                    ref_v[s][k] = 1'b1; ref_t[s][k] = tag; ref_p[s][k] = ppn;
                end
            end
        end
        expq.push_back(e);
        return hw >= 0;
    endfunction

    exp_t mon_e;
    int   mon_t;

    always @(negedge clk) begin
        if (!rst) begin
            if (o_resp_valid) begin
                if (expq.size() == 0 || tq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_resp actual=valid ppn=%0h required=no response (cycle %0d)",
                             o_resp_ppn, cyc);
                end else begin
                    mon_e = expq.pop_front();
                    mon_t = tq.pop_front();
                    chk("resp_cycle", 64'(cyc), 64'(mon_t));
                    chk("resp_hit", 64'(o_resp_hit), 64'(mon_e.hit));
                    chk("resp_fault", 64'(o_resp_fault), 64'(mon_e.fault));
                    chk("resp_ppn", 64'(o_resp_ppn), 64'(mon_e.ppn));
                    chk("update_way", 64'(o_update_way_4), 64'(mon_e.way));
                    chk("wr_en", 64'(o_wr_en), 64'(mon_e.wr));
                    if (mon_e.wr) begin
                        chk("wr_way", 64'(o_wr_way_4), 64'(mon_e.way));
                        chk("wr_set", 64'(o_wr_set), 64'(mon_e.vpn[SET_W-1:0]));
                        chk("wr_tag", 64'(o_wr_tag), 64'(mon_e.vpn[VPN_W-1:SET_W]));
                        chk("wr_ppn", 64'(o_wr_ppn), 64'(mon_e.ppn));
                    end
                end
            end else begin
                chk("quiet_wr_en", 64'(o_wr_en), 64'd0);
                chk("quiet_update", 64'(o_update_way_4), 64'd0);
            end
        end
    end

    task automatic send_req(input logic [VPN_W-1:0] vpn, input bit hit);
        int n = 0;
        @(posedge clk); #1;
        i_req_valid = 1'b1;
        i_req_vpn   = vpn;
        @(negedge clk);
        while (!o_req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready", 64'(o_req_ready), 64'd1);
        chk("rd_en", 64'(o_rd_en), 64'd1);
        chk("rd_set", 64'(o_rd_set), 64'(vpn[SET_W-1:0]));
        if (hit) tq.push_back(cyc + 1);
        @(posedge clk); #1;
        i_req_valid = 1'b0;
    endtask

    task automatic ptw_handshake(input logic [VPN_W-1:0] vpn, input int delay, input int bound);
        int n = 0;
        repeat (delay) @(posedge clk);
        #1;
        i_ptw_req_ready = 1'b1;
        @(negedge clk);
        while (!o_ptw_req_valid && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk("ptw_req_valid", 64'(o_ptw_req_valid), 64'd1);
        chk("ptw_req_vpn", 64'(o_ptw_req_vpn), 64'(vpn));
        @(posedge clk); #1;
        i_ptw_req_ready = 1'b0;
    endtask

    task automatic ptw_respond(input bit fault, input logic [PPN_W-1:0] ppn, input int delay);
        repeat (delay) @(posedge clk);
        #1;
        i_ptw_resp_valid = 1'b1;
        i_ptw_resp_fault = fault;
        i_ptw_resp_ppn   = ppn;
        tq.push_back(fault ? cyc : cyc + 1);
        @(posedge clk); #1;
        i_ptw_resp_valid = 1'b0;
        i_ptw_resp_fault = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (expq.size() > 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 64'(expq.size()), 64'd0);
    endtask

    task automatic do_txn(input logic [VPN_W-1:0] vpn, input logic [3:0] repl,
                          input bit fault, input logic [PPN_W-1:0] ppn);
        bit hit;
        i_replace_way_4 = repl;
        hit = predict(vpn, repl, fault, ppn);
        send_req(vpn, hit);
        if (hit) begin
            repeat (2) begin
                @(negedge clk);
                chk("hit_no_ptw", 64'(o_ptw_req_valid), 64'd0);
            end
        end else begin
            ptw_handshake(vpn, int'($urandom_range(0, 2)), 40);
            ptw_respond(fault, ppn, int'($urandom_range(0, 2)));
        end
        wait_drain();
    endtask

    function automatic logic [VPN_W-1:0] mkvpn(input int tag, input int set);
        return {TAG_W'(tag), SET_W'(set)};
    endfunction

    task automatic chk_all_quiet(input string tag);
        chk({tag, "_ready"}, 64'(o_req_ready), 64'd0);
        chk({tag, "_resp"}, 64'(o_resp_valid), 64'd0);
        chk({tag, "_ptw"}, 64'(o_ptw_req_valid), 64'd0);
        chk({tag, "_wr"}, 64'(o_wr_en), 64'd0);
        chk({tag, "_upd"}, 64'(o_update_way_4), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        logic [VPN_W-1:0] va;
        logic [PPN_W-1:0] rp;

        for (int s = 0; s < NS; s++) begin
            for (int k = 0; k < 4; k++) begin
                mem_v[s][k] = 0; mem_t[s][k] = '0; mem_p[s][k] = '0;
            end
        end
        mem_v[8][2]  = 1; mem_t[8][2]  = 21'h77; mem_p[8][2]  = 44'h123;
        mem_v[10][0] = 1; mem_t[10][0] = 21'h1;  mem_p[10][0] = 44'h10;
        mem_v[10][1] = 1; mem_t[10][1] = 21'h2;  mem_p[10][1] = 44'h11;
        mem_v[10][3] = 1; mem_t[10][3] = 21'h3;  mem_p[10][3] = 44'h13;
        for (int k = 0; k < 4; k++) begin
            mem_v[11][k] = 1; mem_t[11][k] = TAG_W'(k + 1); mem_p[11][k] = PPN_W'(32 + k);
        end
        mem_v[12][0] = 1; mem_t[12][0] = 21'h6; mem_p[12][0] = 44'hA0;
        mem_v[12][1] = 1; mem_t[12][1] = 21'h5; mem_p[12][1] = 44'hA1;
        mem_v[12][3] = 1; mem_t[12][3] = 21'h5; mem_p[12][3] = 44'hA3;
        for (int s = 0; s < NS; s++) begin
            for (int k = 0; k < 4; k++) begin
                ref_v[s][k] = mem_v[s][k]; ref_t[s][k] = mem_t[s][k]; ref_p[s][k] = mem_p[s][k];
            end
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_quiet("in_reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_ready", 64'(o_req_ready), 64'd1);

        do_txn(mkvpn(32'h77, 8), 4'b0001, 1'b0, 44'h0);
        do_txn(mkvpn(32'h9, 10), 4'b0001, 1'b0, 44'h55);
        do_txn(mkvpn(32'h9, 11), 4'b0010, 1'b0, 44'h66);
        do_txn(mkvpn(32'h8, 12), 4'b0001, 1'b1, 44'h99);
        do_txn(mkvpn(32'h5, 12), 4'b0001, 1'b0, 44'h0);
        do_txn(mkvpn(32'h9, 10), 4'b0001, 1'b0, 44'h0);

        // Flush while the walk is outstanding; the next miss must wait for the stale reply.
        va = mkvpn(32'h30, 13);
        send_req(va, 1'b0);
        ptw_handshake(va, 0, 40);
        i_flush = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        i_flush = 1'b0;
        va = mkvpn(32'h31, 13);
        i_replace_way_4 = 4'b1000;
        void'(predict(va, 4'b1000, 1'b0, 44'h777));
        send_req(va, 1'b0);
        i_ptw_req_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("drop_hold_ptw", 64'(o_ptw_req_valid), 64'd0);
        end
        @(posedge clk); #1;
        i_ptw_resp_valid = 1'b1;
        i_ptw_resp_ppn   = 44'hBAD;
        @(negedge clk);
        chk("stale_ptw_hold", 64'(o_ptw_req_valid), 64'd0);
        @(posedge clk); #1;
        i_ptw_resp_valid = 1'b0;
        i_ptw_req_ready  = 1'b0;
        ptw_handshake(va, 0, 4);
        ptw_respond(1'b0, 44'h777, 1);
        wait_drain();

        // Reset during a walk clears everything, including the drop flag.
        va = mkvpn(32'h32, 14);
        send_req(va, 1'b0);
        ptw_handshake(va, 0, 40);
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk_all_quiet("reset_mid_walk");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_ready2", 64'(o_req_ready), 64'd1);
        va = mkvpn(32'h33, 14);
        i_replace_way_4 = 4'b0001;
        void'(predict(va, 4'b0001, 1'b0, 44'h3333));
        send_req(va, 1'b0);
        ptw_handshake(va, 0, 2);
        ptw_respond(1'b0, 44'h3333, 0);
        wait_drain();

        for (int i = 0; i < 200; i++) begin
            rp = {$urandom, $urandom};
            do_txn(mkvpn(int'($urandom_range(0, 5)), int'($urandom_range(0, 3))),
                   4'(1 << $urandom_range(0, 3)), ($urandom_range(0, 5) == 0), rp);
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
